// File: rtl/fpcvt_normalize_if.sv
// Handshake and result bundle for the 12-bit-linear to 8-bit-float normaliser.
//   master : drives start/d, observes busy/done and the result fields
//   slave  : the normaliser itself
// Signals:
//   start  - conversion request, honoured only when the slave is not busy
//   d      - two's-complement input sample
//   busy   - conversion in progress
//   done   - one-cycle pulse, result fields valid from this cycle onward
//   sign, exp, sfcand, fifthb - sign, exponent, truncated significand, round bit
interface fpcvt_normalize_if #(
    parameter int EXP_W = 3,
    parameter int SIG_W = 4,
    parameter int IN_W  = 12
);
    logic             start;
    logic [IN_W-1:0]  d;
    logic             busy;
    logic             done;
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [SIG_W-1:0] sfcand;
    logic             fifthb;

    modport master (
        output start, d,
        input  busy, done, sign, exp, sfcand, fifthb
    );

    modport slave (
        input  start, d,
        output busy, done, sign, exp, sfcand, fifthb
    );
endinterface

// File: rtl/fpcvt_normalize.sv
// Sequential front-end of the 12-bit-linear to 8-bit-float converter.
// Takes a two's-complement sample, forms sign-magnitude, then normalises the
// magnitude with a serial left shift (one bit per clock) while counting the
// exponent down. The registered sign/exp/sfcand/fifthb feed the rounding stage.
// Ports:
//   clk - system clock, rising edge
//   rst - synchronous active-high reset
//   bus - fpcvt_normalize_if slave: start/d in; busy/done/sign/exp/sfcand/fifthb out
// IN_W must equal 2**EXP_W + SIG_W; other combinations are unsupported.
module fpcvt_normalize #(
    parameter int EXP_W = 3,
    parameter int SIG_W = 4,
    parameter int IN_W  = 12
) (
    input logic              clk,
    input logic              rst,
    fpcvt_normalize_if.slave bus
);

    localparam logic [EXP_W-1:0] ECNT_MAX = '1;
    localparam logic [IN_W-1:0]  MOST_NEG = {1'b1, {(IN_W-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StConv, StShift, StOut} state_e;

    state_e           state_q, state_d;
    logic [IN_W-1:0]  d_q;
    logic [IN_W-1:0]  shreg_q;
    logic [EXP_W-1:0] ecnt_q;
    logic             sign_in_q;
    logic             sign_q;
    logic [EXP_W-1:0] exp_q;
    logic [SIG_W-1:0] sfcand_q;
    logic             fifthb_q;

    logic [IN_W-1:0]  mag;
    logic             accept;
    logic             norm_done;
    logic             busy;
    logic             done;

    // A start in the OUT cycle is accepted so conversions can run back-to-back.
    assign accept    = bus.start && (state_q == StIdle || state_q == StOut);
    // Stop once the leading one reaches the bit just below the sign, or the
    // exponent bottoms out (denormal-style result with exp = 0).
    assign norm_done = shreg_q[IN_W-2] || (ecnt_q == '0);

    // Most-negative input has no positive counterpart; saturate it.
    always_comb begin
        mag = d_q;
        if (d_q == MOST_NEG) begin
            mag = ~MOST_NEG;
        end else if (d_q[IN_W-1]) begin
            mag = -d_q;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StConv;
            StConv:  state_d = StShift;
            StShift: if (norm_done) state_d = StOut;
            StOut:   state_d = accept ? StConv : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            StConv, StShift: busy = 1'b1;
            StOut:           done = 1'b1;
            default:         ;
        endcase
    end

    // Datapath: capture, magnitude load, serial shift and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q       <= '0;
            shreg_q   <= '0;
            ecnt_q    <= '0;
            sign_in_q <= 1'b0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            sfcand_q  <= '0;
            fifthb_q  <= 1'b0;
        end else begin
            if (accept) begin
                d_q <= bus.d;
            end
            if (state_q == StConv) begin
                shreg_q   <= mag;
                ecnt_q    <= ECNT_MAX;
                sign_in_q <= d_q[IN_W-1];
            end
            if (state_q == StShift) begin
                if (norm_done) begin
                    sign_q   <= sign_in_q;
                    exp_q    <= ecnt_q;
                    sfcand_q <= shreg_q[IN_W-2 -: SIG_W];
                    fifthb_q <= shreg_q[IN_W-2-SIG_W];
                end else begin
                    shreg_q <= shreg_q << 1;
                    ecnt_q  <= ecnt_q - 1'b1;
                end
            end
        end
    end

    assign bus.busy   = busy;
    assign bus.done   = done;
    assign bus.sign   = sign_q;
    assign bus.exp    = exp_q;
    assign bus.sfcand = sfcand_q;
    assign bus.fifthb = fifthb_q;

endmodule
